// File: rtl/flight_read_arbiter_if.sv
// rtl/flight_read_arbiter_if.sv - flight buffer read-port sharing bus
// slave is the arbiter side, master is the requesters plus the buffer.
interface flight_read_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              frame;
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] start0;
  logic [ADDR_W-1:0] start1;
  logic [ADDR_W-1:0] len0;
  logic [ADDR_W-1:0] len1;
  logic              gnt0;
  logic              gnt1;
  logic              vld0;
  logic              vld1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              done0;
  logic              done1;
  logic [ADDR_W-1:0] rd_FLIGHT;
  logic [DATA_W-1:0] FLIGHT_out;

  modport slave (
    input  frame, req0, req1, start0, start1, len0, len1, FLIGHT_out,
    output gnt0, gnt1, vld0, vld1, data0, data1, done0, done1, rd_FLIGHT
  );

  modport master (
    output frame, req0, req1, start0, start1, len0, len1, FLIGHT_out,
    input  gnt0, gnt1, vld0, vld1, data0, data1, done0, done1, rd_FLIGHT
  );
endinterface

// File: rtl/flight_read_arbiter.sv
// rtl/flight_read_arbiter.sv - round-robin burst arbiter for the flight buffer read port
// Requester 0 is the CC audio+data transmitter, requester 1 the LPC transmitter.
module flight_read_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  flight_read_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               w_grant;
  logic               w_sel;
  logic               w_issue;
  logic               w_issue_last;

  logic               r_ptr;
  logic               r_owner;
  logic               r_gnt0;
  logic               r_gnt1;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_remaining;

  logic [RD_LAT-1:0]  r_pipe;
  logic [RD_LAT-1:0]  r_pipe_last;
  logic [RD_LAT-1:0]  w_pipe_next;
  logic [RD_LAT-1:0]  w_pipe_last_next;
  logic               r_vld0;
  logic               r_vld1;
  logic               r_done0;
  logic               r_done1;
  logic [DATA_W-1:0]  r_data;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // r_remaining counts addresses still to issue after the current one, so a
  // length of 0 naturally becomes 2^ADDR_W words.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_sel        = r_ptr;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.frame && (bus.req0 || bus.req1)) begin
          w_grant      = 1'b1;
          w_sel        = (bus.req0 && bus.req1) ? r_ptr : bus.req1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        if (r_remaining == '0) begin
          w_issue_last = 1'b1;
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_done0 || r_done1) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      r_gnt0 <= w_grant & ~w_sel;
      r_gnt1 <= w_grant & w_sel;
      if (w_grant) begin
        r_owner     <= w_sel;
        r_addr      <= w_sel ? bus.start1 : bus.start0;
        r_remaining <= (w_sel ? bus.len1 : bus.len0) - ADDR_W'(1);
      end else if (w_issue && !w_issue_last) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - ADDR_W'(1);
      end
      if (r_state == S_DRAIN && (r_done0 || r_done1)) begin
        r_ptr <= ~r_owner;
      end
    end
  end

  // Tags travel alongside each issued address and mature when its data does.
  generate
    if (RD_LAT == 1) begin : g_pipe_one
      assign w_pipe_next      = w_issue;
      assign w_pipe_last_next = w_issue_last;
    end else begin : g_pipe_deep
      assign w_pipe_next      = {r_pipe[RD_LAT-2:0], w_issue};
      assign w_pipe_last_next = {r_pipe_last[RD_LAT-2:0], w_issue_last};
    end
  endgenerate

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pipe      <= '0;
      r_pipe_last <= '0;
      r_vld0      <= 1'b0;
      r_vld1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_data      <= '0;
    end else begin
      r_pipe      <= w_pipe_next;
      r_pipe_last <= w_pipe_last_next;
      r_vld0      <= r_pipe[RD_LAT-1] & ~r_owner;
      r_vld1      <= r_pipe[RD_LAT-1] & r_owner;
      r_done0     <= r_pipe_last[RD_LAT-1] & ~r_owner;
      r_done1     <= r_pipe_last[RD_LAT-1] & r_owner;
      if (r_pipe[RD_LAT-1]) begin
        r_data <= bus.FLIGHT_out;
      end
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.vld0      = r_vld0;
  assign bus.vld1      = r_vld1;
  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.data0     = r_data;
  assign bus.data1     = r_data;
  assign bus.rd_FLIGHT = r_addr;

endmodule

// File: tb/tb_flight_read_arbiter.sv
// tb/tb_flight_read_arbiter.sv - directed bench for flight_read_arbiter
// Buffer model returns 0xCAFE0000 | address two clocks after the address.
module tb_flight_read_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [ADDR_W-1:0] r_a_d1;
  logic [ADDR_W-1:0] r_a_d2;

  flight_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  flight_read_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (bus_if)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    r_a_d1 <= bus_if.rd_FLIGHT;
    r_a_d2 <= r_a_d1;
  end

  assign bus_if.FLIGHT_out = 32'hCAFE_0000 | {24'h0, r_a_d2};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt0"}, bus_if.gnt0, 1'b0);
    chk({tag, "_gnt1"}, bus_if.gnt1, 1'b0);
    chk({tag, "_vld0"}, bus_if.vld0, 1'b0);
    chk({tag, "_vld1"}, bus_if.vld1, 1'b0);
    chk({tag, "_done0"}, bus_if.done0, 1'b0);
    chk({tag, "_done1"}, bus_if.done1, 1'b0);
    chk({tag, "_data0"}, bus_if.data0, 32'h0);
    chk({tag, "_data1"}, bus_if.data1, 32'h0);
    chk({tag, "_rd"}, bus_if.rd_FLIGHT, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
  endtask

  // Called in the grant cycle (cycle 0); returns in cycle n+3 (back in IDLE).
  task automatic run_burst(input bit who, input logic [7:0] st, input int n);
    int          nv;
    logic [7:0]  a;
    logic [7:0]  dw;
    string       t;
    bit          v_exp;
    nv = 0;
    for (int c = 0; c <= n + 2; c++) begin
      t = $sformatf("r%0d_s%0h_c%0d", who, st, c);
      a = (c < n) ? st + 8'(c) : st + 8'(n - 1);
      v_exp = (c >= RD_LAT + 1) && (c <= n + RD_LAT);
      chk({t, "_gnt_own"}, who ? bus_if.gnt1 : bus_if.gnt0, c == 0);
      chk({t, "_gnt_oth"}, who ? bus_if.gnt0 : bus_if.gnt1, 1'b0);
      chk({t, "_rd"}, bus_if.rd_FLIGHT, a);
      chk({t, "_vld_own"}, who ? bus_if.vld1 : bus_if.vld0, v_exp);
      chk({t, "_vld_oth"}, who ? bus_if.vld0 : bus_if.vld1, 1'b0);
      chk({t, "_done_own"}, who ? bus_if.done1 : bus_if.done0, c == n + RD_LAT);
      chk({t, "_done_oth"}, who ? bus_if.done0 : bus_if.done1, 1'b0);
      if (v_exp) begin
        dw = st + 8'(c - RD_LAT - 1);
        chk({t, "_data0"}, bus_if.data0, 32'hCAFE_0000 | {24'h0, dw});
        chk({t, "_data1"}, bus_if.data1, 32'hCAFE_0000 | {24'h0, dw});
      end
      if (who ? bus_if.vld1 : bus_if.vld0) nv++;
      if (c == 0) begin
        if (who) bus_if.req1 = 1'b0;
        else     bus_if.req0 = 1'b0;
      end
      tick();
    end
    chk($sformatf("r%0d_s%0h_vld_count", who, st), nv, n);
  endtask

  initial begin
    bus_if.frame  = 1'b0;
    bus_if.req0   = 1'b0;
    bus_if.req1   = 1'b0;
    bus_if.start0 = 8'h00;
    bus_if.start1 = 8'h00;
    bus_if.len0   = 8'h00;
    bus_if.len1   = 8'h00;
    do_reset();
    tick();

    // Contested start after reset, then alternation 0,1,0,1,0,1
    bus_if.req0 = 1'b1; bus_if.start0 = 8'h20; bus_if.len0 = 8'd2;
    bus_if.req1 = 1'b1; bus_if.start1 = 8'h40; bus_if.len1 = 8'd2;
    tick();
    run_burst(1'b0, 8'h20, 2);
    chk("alt_idle_gnt1", bus_if.gnt1, 1'b0);
    tick();
    run_burst(1'b1, 8'h40, 2);
    bus_if.req0 = 1'b1;
    bus_if.req1 = 1'b1;
    tick();
    run_burst(1'b0, 8'h20, 2);
    bus_if.req0 = 1'b1;
    tick();
    run_burst(1'b1, 8'h40, 2);
    bus_if.req1 = 1'b1;
    tick();
    run_burst(1'b0, 8'h20, 2);
    tick();
    run_burst(1'b1, 8'h40, 2);

    // Plain burst on requester 0
    bus_if.req0 = 1'b1; bus_if.start0 = 8'h10; bus_if.len0 = 8'd4;
    tick();
    run_burst(1'b0, 8'h10, 4);

    // Address wrap on requester 1
    bus_if.req1 = 1'b1; bus_if.start1 = 8'hFE; bus_if.len1 = 8'd3;
    tick();
    run_burst(1'b1, 8'hFE, 3);

    // len=0 means a full 256-word sweep
    bus_if.req0 = 1'b1; bus_if.start0 = 8'h00; bus_if.len0 = 8'd0;
    tick();
    run_burst(1'b0, 8'h00, 256);

    // frame blocks grants while high
    bus_if.frame = 1'b1;
    bus_if.req0 = 1'b1; bus_if.start0 = 8'h30; bus_if.len0 = 8'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("frame_block_%0d", i), bus_if.gnt0, 1'b0);
    end
    bus_if.frame = 1'b0;
    tick();
    run_burst(1'b0, 8'h30, 2);

    // frame rising mid-burst lets the burst finish but holds off the next one
    bus_if.req0 = 1'b1; bus_if.start0 = 8'h38; bus_if.len0 = 8'd3;
    tick();
    bus_if.frame = 1'b1;
    bus_if.req1 = 1'b1; bus_if.start1 = 8'h70; bus_if.len1 = 8'd1;
    run_burst(1'b0, 8'h38, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frame_hold_%0d", i), bus_if.gnt1, 1'b0);
    end
    bus_if.frame = 1'b0;
    tick();
    run_burst(1'b1, 8'h70, 1);

    // Reset in cycle 3 of a len=8 burst
    bus_if.req0 = 1'b1; bus_if.start0 = 8'h50; bus_if.len0 = 8'd8;
    tick();
    chk("rst_mid_gnt0", bus_if.gnt0, 1'b1);
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b1; bus_if.start1 = 8'h60; bus_if.len1 = 8'd2;
    tick();
    tick();
    tick();
    chk("rst_mid_vld0_before", bus_if.vld0, 1'b1);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    reset = 1'b0;
    tick();
    run_burst(1'b1, 8'h60, 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post_rst_vld0_%0d", i), bus_if.vld0, 1'b0);
      chk($sformatf("post_rst_done0_%0d", i), bus_if.done0, 1'b0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
